// File: rtl/alert_beep_scheduler.sv
// Alert beep scheduler: edge-latches four alert requests, serves them by fixed
// priority, and emits one trigger pulse per beep. Optional ALERT_MUTE_EN adds a mute input.
module alert_beep_scheduler #(
  parameter int unsigned BEEP_CYCLES = 100_000_000,
  parameter int unsigned GAP_CYCLES  = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] event_req,
`ifdef ALERT_MUTE_EN
  input  logic       mute,
`endif
  output logic       trigger,
  output logic       busy,
  output logic [1:0] active_id
);

  localparam logic [31:0] BEEP_LAST = 32'(BEEP_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FIRE, BEEP, GAP} state_t;

  state_t      state, state_nx;
  logic [31:0] count, count_nx;
  logic [1:0]  beeps_left, beeps_left_nx;
  logic [1:0]  active_id_nx, sel;
  logic [3:0]  pending, pending_nx, req_prev, clear_mask;
  logic        trigger_nx, muted;

`ifdef ALERT_MUTE_EN
  assign muted = mute;
`else
  assign muted = 1'b0;
`endif

  // Lowest set pending bit wins.
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) sel = 2'(i);
    end
  end

  always_comb begin
    state_nx      = state;
    count_nx      = count;
    beeps_left_nx = beeps_left;
    active_id_nx  = active_id;
    trigger_nx    = 1'b0;
    clear_mask    = 4'b0000;
    case (state)
      IDLE: begin
        if ((pending != 4'b0000) && !muted) begin
          active_id_nx  = sel;
          beeps_left_nx = sel;
          clear_mask    = 4'b0001 << sel;
          trigger_nx    = 1'b1;
          state_nx      = FIRE;
        end
      end
      FIRE: begin
        count_nx = 32'd0;
        state_nx = BEEP;
      end
      BEEP: begin
        if (count == BEEP_LAST) begin
          count_nx = 32'd0;
          state_nx = GAP;
        end else begin
          count_nx = count + 32'd1;
        end
      end
      GAP: begin
        if (count == GAP_LAST) begin
          count_nx = 32'd0;
          if (beeps_left != 2'd0) begin
            beeps_left_nx = beeps_left - 2'd1;
            trigger_nx    = 1'b1;
            state_nx      = FIRE;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          count_nx = count + 32'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A fresh edge on the bit being cleared re-queues it.
    pending_nx = (pending & ~clear_mask) | (event_req & ~req_prev);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= 32'd0;
      beeps_left <= 2'd0;
      active_id  <= 2'd0;
      pending    <= 4'b0000;
      req_prev   <= 4'b0000;
      trigger    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      beeps_left <= beeps_left_nx;
      active_id  <= active_id_nx;
      pending    <= pending_nx;
      req_prev   <= event_req;
      trigger    <= trigger_nx;
      busy       <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_alert_beep_scheduler.sv
// Bench for alert_beep_scheduler: directed table, corner sequences and random
// stimulus checked cycle by cycle against a schedule-based reference model.
module tb_alert_beep_scheduler;
  localparam int B = 8;
  localparam int G = 4;
  localparam int P = 1 + B + G;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] event_req = 4'b0000;
  logic       mute = 1'b0;
  logic       trigger, busy;
  logic [1:0] active_id;

  always #5 clk = ~clk;

  alert_beep_scheduler #(.BEEP_CYCLES(B), .GAP_CYCLES(G)) dut (
    .clk(clk),
    .reset(reset),
    .event_req(event_req),
`ifdef ALERT_MUTE_EN
    .mute(mute),
`endif
    .trigger(trigger),
    .busy(busy),
    .active_id(active_id)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a sequence started at edge s for alert ci fires at
  // s + k*P (k = 0..ci), keeps busy over (s, s + P*(ci+1)], and frees the
  // scheduler for a new start one edge after that.
  int         cyc = 0, s = 0, ci = 0, next_free = 0;
  bit         has_run = 1'b0;
  logic [3:0] prev = 4'b0000, pend = 4'b0000;
  logic [1:0] mid = 2'd0;
  logic       e_trig, e_busy;

  int trig_cnt, trig0_cnt, busy_cnt, first_trig;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    prev = 4'b0000; pend = 4'b0000; has_run = 1'b0; mid = 2'd0; next_free = 0;
  endtask

  task automatic model_edge();
    int pick;
    pick = -1;
    if (cyc >= next_free && pend != 4'b0000 && !mute) begin
      for (int i = 0; i < 4; i++) if (pend[i] && pick < 0) pick = i;
      s = cyc; ci = pick; mid = 2'(pick); has_run = 1'b1;
      next_free = cyc + P * (pick + 1) + 1;
      pend[pick] = 1'b0;
    end
    pend = pend | (event_req & ~prev);
    prev = event_req;
  endtask

  task automatic step();
    int d;
    @(posedge clk);
    cyc++;
    if (!reset) model_reset();
    else model_edge();
    d = cyc - s;
    e_trig = has_run && d >= 0 && (d % P) == 0 && (d / P) <= ci;
    e_busy = has_run && d >= 1 && d <= P * (ci + 1);
    #1;
    check("cycle", {29'd0, trigger, busy, active_id}, {29'd0, e_trig, e_busy, mid});
    if (trigger) begin
      trig_cnt++;
      if (active_id == 2'd0) trig0_cnt++;
      if (first_trig < 0) first_trig = cyc;
    end
    if (busy) busy_cnt++;
  endtask

  task automatic clr_counts();
    trig_cnt = 0; trig0_cnt = 0; busy_cnt = 0; first_trig = -1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic [3:0] req;
    int         trigs;
    int         busy_cycles;
    logic [1:0] id;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int pulse_edge, g;
    tbl[0] = '{4'b0001,  1,  13, 2'd0};
    tbl[1] = '{4'b1000,  4,  52, 2'd3};
    tbl[2] = '{4'b0000,  0,   0, 2'd3};
    tbl[3] = '{4'b0110,  5,  65, 2'd2};
    tbl[4] = '{4'b0100,  3,  39, 2'd2};
    tbl[5] = '{4'b1111, 10, 130, 2'd3};
    tbl[6] = '{4'b0010,  2,  26, 2'd1};
    clr_counts();

    #1;
    check("rst_trigger", {31'd0, trigger}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_id", {30'd0, active_id}, 32'd0);
    run(3);
    reset = 1'b1;
    run(3);

    for (int k = 0; k < 7; k++) begin
      clr_counts();
      event_req = tbl[k].req;
      step();
      pulse_edge = cyc;
      event_req = 4'b0000;
      run(140);
      check($sformatf("tbl%0d_trigs", k), trig_cnt, tbl[k].trigs);
      check($sformatf("tbl%0d_busy", k), busy_cnt, tbl[k].busy_cycles);
      check($sformatf("tbl%0d_id", k), {30'd0, active_id}, {30'd0, tbl[k].id});
      if (tbl[k].trigs > 0)
        check($sformatf("tbl%0d_latency", k), first_trig - pulse_edge, 1);
    end

    // Coalesce: three bit-0 edges during an alert-3 sequence give one service.
    clr_counts();
    event_req = 4'b1000; step(); event_req = 4'b0000; run(5);
    for (int r = 0; r < 3; r++) begin
      event_req = 4'b0001; run(2); event_req = 4'b0000; run(3);
    end
    run(70);
    check("coalesce_trigs", trig_cnt, 5);
    check("coalesce_alert0", trig0_cnt, 1);

    // Re-arm: a bit-0 edge on the very edge that starts alert-0 service.
    clr_counts();
    event_req = 4'b0010; step(); event_req = 4'b0000; run(3);
    event_req = 4'b0001; step(); event_req = 4'b0000;
    g = 0;
    while (cyc + 1 != next_free && g < 100) begin step(); g++; end
    check("rearm_wait", {31'd0, g < 100}, 32'd1);
    event_req = 4'b0001; step(); event_req = 4'b0000;
    run(40);
    check("rearm_alert0", trig0_cnt, 2);
    check("rearm_trigs", trig_cnt, 4);

    // Request held high through reset release counts as an edge.
    reset = 1'b0; event_req = 4'b0001;
    run(2);
    reset = 1'b1;
    clr_counts();
    run(30);
    check("held_trigs", trig_cnt, 1);
    event_req = 4'b0000;
    run(3);

    // Reset asserted mid-BEEP drops outputs at once and forgets the sequence.
    event_req = 4'b0100; step(); event_req = 4'b0000;
    run(5);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_trig", {31'd0, trigger}, 32'd0);
    run(2);
    reset = 1'b1;
    clr_counts();
    run(50);
    check("post_rst_trigs", trig_cnt, 0);

`ifdef ALERT_MUTE_EN
    mute = 1'b1;
    clr_counts();
    event_req = 4'b0100; step(); event_req = 4'b0000;
    run(30);
    check("muted_trigs", trig_cnt, 0);
    mute = 1'b0;
    clr_counts();
    step();
    check("unmute_latency", {31'd0, trigger}, 32'd1);
    run(50);
    check("unmute_trigs", trig_cnt, 3);
`endif

    // Random phase: sparse bit toggles, occasional mute, one reset.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        int b;
        b = $urandom_range(0, 3);
        event_req[b] = ~event_req[b];
      end
`ifdef ALERT_MUTE_EN
      if ($urandom_range(0, 39) == 0) mute = ~mute;
`endif
      if (n == 700) reset = 1'b0;
      if (n == 703) reset = 1'b1;
      step();
    end
    mute = 1'b0;
    event_req = 4'b0000;
    run(200);
    check("drain_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
